// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU port, debug port and the shared memory port.
// The arbiter connects through `slave`; requesters and the memory use `master`.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_hold;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              dbg_lock;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_hold,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_hold,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the CPU and a debug/loader port.
// Define ARB_PERF_EN to add saturating grant and conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       dbg_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside the legal range 1..15", MEM_LAT);
  end

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  owner_t            grant_owner;
  logic [3:0]        lat_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              lock_q;

  logic              cpu_elig;
  logic              dbg_elig;
  logic              grant_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // While debug holds the lock the CPU is simply not a candidate.
  assign cpu_elig    = bus.cpu_req & ~bus.dbg_lock;
  assign dbg_elig    = bus.dbg_req;
  assign grant_valid = (state == IDLE) & (cpu_elig | dbg_elig);
  assign grant_owner = (cpu_elig & dbg_elig) ? ((last_grant == OWN_DBG) ? OWN_CPU : OWN_DBG)
                                             : (dbg_elig ? OWN_DBG : OWN_CPU);

  assign sel_we    = (grant_owner == OWN_DBG) ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = (grant_owner == OWN_DBG) ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = (grant_owner == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = lock_q & bus.cpu_req;

  // NOTE: every register here uses <= so all of them update from the same pre-edge values;
  // a blocking = would let later statements see half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      last_grant    <= OWN_DBG;
      lat_cnt       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lock_q        <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      lock_q      <= bus.dbg_lock;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            last_grant <= grant_owner;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            lat_cnt    <= 4'(MEM_LAT - 1);
            bus.mem_en <= 1'b1;
            bus.mem_we <= sel_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= RESP;
            // The ack register is loaded here so it is high for exactly the RESP cycle.
            if (owner == OWN_DBG) begin
              bus.dbg_ack <= 1'b1;
              if (!we_q) bus.dbg_rdata <= bus.mem_rdata;
            end else begin
              bus.cpu_ack <= 1'b1;
              if (!we_q) bus.cpu_rdata <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  logic conflict;
  assign conflict = (state == IDLE) & cpu_elig & dbg_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_grant_cnt <= '0;
      dbg_grant_cnt <= '0;
      conflict_cnt  <= '0;
    end else begin
      if (grant_valid && grant_owner == OWN_CPU && cpu_grant_cnt != 16'hFFFF)
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (grant_valid && grant_owner == OWN_DBG && dbg_grant_cnt != 16'hFFFF)
        dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
      if (conflict && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus lock, back-to-back and reset sequences.
// Expected acks are queued when stimulus is driven and compared by a monitor when an ack appears.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  typedef struct {
    bit          cpu_req;
    bit          cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    bit          dbg_req;
    bit          dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    bit          lock;
    bit          exp_dbg;
  } vec_t;

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    logic [31:0] other;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[11];
  logic [31:0] ref_mem[256];
  logic [31:0] model_cpu_rdata = '0;
  logic [31:0] model_dbg_rdata = '0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

`ifdef ARB_PERF_EN
  logic [15:0] cpu_grant_cnt;
  logic [15:0] dbg_grant_cnt;
  logic [15:0] conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef ARB_PERF_EN
    ,
    .cpu_grant_cnt(cpu_grant_cnt),
    .dbg_grant_cnt(dbg_grant_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: read data is only valid in the last cycle of the MEM_LAT-long enable window.
  logic [31:0] mem[256];
  int en_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_cnt      <= 0;
      mem[8'h10]  <= 32'hDEADBEEF;
    end else begin
      en_cnt <= bus_if.mem_en ? en_cnt + 1 : 0;
      if (bus_if.mem_en && bus_if.mem_we) mem[bus_if.mem_addr[7:0]] <= bus_if.mem_wdata;
    end
  end
  assign bus_if.mem_rdata = (bus_if.mem_en && en_cnt == LAT - 1) ? mem[bus_if.mem_addr[7:0]]
                                                                 : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic push_exp(input bit dbg, input bit we, input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    if (we) ref_mem[a] = wd;
    else if (dbg) model_dbg_rdata = ref_mem[a];
    else model_cpu_rdata = ref_mem[a];
    e.dbg   = dbg;
    e.rdata = dbg ? model_dbg_rdata : model_cpu_rdata;
    e.other = dbg ? model_cpu_rdata : model_dbg_rdata;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus_if.cpu_ack || bus_if.dbg_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus_if.dbg_ack), 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_exclusive", 32'(bus_if.cpu_ack & bus_if.dbg_ack), 0);
        check("ack_owner_is_dbg", 32'(bus_if.dbg_ack), 32'(e.dbg));
        if (e.dbg) begin
          check("dbg_rdata", bus_if.dbg_rdata, e.rdata);
          check("cpu_rdata_kept", bus_if.cpu_rdata, e.other);
        end else begin
          check("cpu_rdata", bus_if.cpu_rdata, e.rdata);
          check("dbg_rdata_kept", bus_if.dbg_rdata, e.other);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    bus_if.cpu_req   = v.cpu_req;
    bus_if.cpu_we    = v.cpu_we;
    bus_if.cpu_addr  = {24'h0, v.cpu_addr};
    bus_if.cpu_wdata = v.cpu_wdata;
    bus_if.dbg_req   = v.dbg_req;
    bus_if.dbg_we    = v.dbg_we;
    bus_if.dbg_addr  = {24'h0, v.dbg_addr};
    bus_if.dbg_wdata = v.dbg_wdata;
    bus_if.dbg_lock  = v.lock;
  endtask

  task automatic drop_reqs();
    bus_if.cpu_req = 1'b0;
    bus_if.dbg_req = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int lat, output int en_c, output int we_c,
                          output bit got);
    lat = 0; en_c = 0; we_c = 0; got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus_if.mem_en) en_c++;
      if (bus_if.mem_we) we_c++;
      if (bus_if.cpu_ack || bus_if.dbg_ack) got = 1'b1;
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int lat, en_c, we_c;
    bit got, we;
    @(negedge clk);
    drive(v);
    we = v.exp_dbg ? v.dbg_we : v.cpu_we;
    push_exp(v.exp_dbg, we, v.exp_dbg ? v.dbg_addr : v.cpu_addr,
             v.exp_dbg ? v.dbg_wdata : v.cpu_wdata);
    wait_ack(20, lat, en_c, we_c, got);
    check({tag, "_ack_seen"}, 32'(got), 1);
    check({tag, "_latency"}, lat, LAT + 1);
    check({tag, "_mem_en_cycles"}, en_c, LAT);
    check({tag, "_mem_we_cycles"}, we_c, we ? LAT : 0);
    if (v.lock) check({tag, "_cpu_hold"}, 32'(bus_if.cpu_hold), 32'(v.cpu_req));
    drop_reqs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drop_reqs();
    bus_if.dbg_lock = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_cpu_rdata = '0;
    model_dbg_rdata = '0;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en_c, we_c, n_ack, last_t, hold_bad;
    bit got, ack_seen;
    vec_t v;

    //          cpu: req we addr  wdata          dbg: req we addr  wdata          lock exp_dbg
    vecs[0]  = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h30, 32'h0,        1'b1, 1'b0, 8'h30, 32'h0,        1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h40, 32'h0,        1'b1, 1'b1, 8'h40, 32'h55AA55AA, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h40, 32'h0,        1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h30, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'h50, 32'hCAFEF00D, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h50, 32'h0,        1'b1, 1'b0, 8'h50, 32'h0,        1'b0, 1'b1};

    ref_mem[8'h10] = 32'hDEADBEEF;

    // Reset state, with a locked CPU request pending to show cpu_hold is also cleared.
    v = '{1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0};
    drive(v);
    repeat (2) @(negedge clk);
    check("rst_cpu_ack", 32'(bus_if.cpu_ack), 0);
    check("rst_dbg_ack", 32'(bus_if.dbg_ack), 0);
    check("rst_cpu_rdata", bus_if.cpu_rdata, 0);
    check("rst_dbg_rdata", bus_if.dbg_rdata, 0);
    check("rst_mem_en", 32'(bus_if.mem_en), 0);
    check("rst_mem_we", 32'(bus_if.mem_we), 0);
    check("rst_mem_addr", bus_if.mem_addr, 0);
    check("rst_mem_wdata", bus_if.mem_wdata, 0);
    check("rst_cpu_hold", 32'(bus_if.cpu_hold), 0);
    drop_reqs();
    bus_if.dbg_lock = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Both requesters held continuously: CPU, DBG, CPU, DBG, one ack every MEM_LAT+2 cycles.
    do_reset();
    @(negedge clk);
    v = '{1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0};
    drive(v);
    for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, i[0] ? 8'h20 : 8'h10, 32'h0);
    n_ack = 0; last_t = 0;
    for (int cyc = 1; cyc <= 40 && n_ack < 4; cyc++) begin
      @(negedge clk);
      if (bus_if.cpu_ack || bus_if.dbg_ack) begin
        if (n_ack == 0) check("rr_first_latency", cyc, LAT + 1);
        else check("rr_ack_spacing", cyc - last_t, LAT + 2);
        last_t = cyc;
        n_ack++;
      end
    end
    check("rr_ack_count", n_ack, 4);
    drop_reqs();

    // Lock raised during a CPU access: CPU still acked, then three DBG grants, then CPU again.
    @(negedge clk);
    drive(v);
    push_exp(1'b0, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 8'h20, 32'h0);
    push_exp(1'b0, 1'b0, 8'h10, 32'h0);
    n_ack = 0; hold_bad = 0;
    for (int cyc = 1; cyc <= 60 && n_ack < 5; cyc++) begin
      @(negedge clk);
      if (bus_if.dbg_lock && cyc >= 2 && !bus_if.cpu_hold) hold_bad++;
      if (cyc == 1) bus_if.dbg_lock = 1'b1;
      if (bus_if.cpu_ack || bus_if.dbg_ack) begin
        n_ack++;
        if (n_ack == 4) bus_if.dbg_lock = 1'b0;
      end
    end
    check("lock_ack_count", n_ack, 5);
    check("lock_cpu_hold_drops", hold_bad, 0);
    drop_reqs();

    // Reset in the second ACCESS cycle: abandoned without ack, then re-granted with full latency.
    @(negedge clk);
    v = '{1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0};
    drive(v);
    repeat (2) @(negedge clk);
    check("midrst_mem_en_before", 32'(bus_if.mem_en), 1);
    rst = 1'b0;
    #1;
    check("midrst_mem_en_now", 32'(bus_if.mem_en), 0);
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.cpu_ack || bus_if.dbg_ack) ack_seen = 1'b1;
    end
    check("midrst_no_ack", 32'(ack_seen), 0);
    model_cpu_rdata = '0;
    model_dbg_rdata = '0;
    rst = 1'b1;
    push_exp(1'b0, 1'b0, 8'h10, 32'h0);
    wait_ack(20, lat, en_c, we_c, got);
    check("midrst_regrant_ack", 32'(got), 1);
    check("midrst_regrant_latency", lat, LAT + 1);
    check("midrst_regrant_mem_en", en_c, LAT);
    drop_reqs();

`ifdef ARB_PERF_EN
    do_reset();
    v = '{1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0};
    run_txn("pf_conf0", v);
    v.exp_dbg = 1'b1;
    run_txn("pf_conf1", v);
    v.exp_dbg = 1'b0;
    run_txn("pf_conf2", v);
    v.dbg_req = 1'b0;
    run_txn("pf_lone0", v);
    run_txn("pf_lone1", v);
    @(negedge clk);
    check("pf_cpu_grant_cnt", 32'(cpu_grant_cnt), 4);
    check("pf_dbg_grant_cnt", 32'(dbg_grant_cnt), 1);
    check("pf_conflict_cnt", 32'(conflict_cnt), 3);
    force dut.cpu_grant_cnt = 16'hFFFE;
    force dut.dbg_grant_cnt = 16'hFFFE;
    force dut.conflict_cnt  = 16'hFFFE;
    @(negedge clk);
    release dut.cpu_grant_cnt;
    release dut.dbg_grant_cnt;
    release dut.conflict_cnt;
    v = '{1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b1};
    run_txn("pf_sat0", v);
    v.exp_dbg = 1'b0;
    run_txn("pf_sat1", v);
    v.exp_dbg = 1'b1;
    run_txn("pf_sat2", v);
    @(negedge clk);
    check("pf_cpu_grant_sat", 32'(cpu_grant_cnt), 32'hFFFF);
    check("pf_dbg_grant_sat", 32'(dbg_grant_cnt), 32'hFFFF);
    check("pf_conflict_sat", 32'(conflict_cnt), 32'hFFFF);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the multicycle CPU and a debug/program-loader port.
- Sequences every memory access: arbitration, fixed-latency access window, registered response with a one-cycle ack.
- The CPU controller stalls its fetch or memory state until cpu_ack.
- The debug port can take exclusive ownership (lock) to load a program while the CPU is held off.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with stable we/addr/wdata until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered read data, valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_hold  out  1  high while dbg_lock is active and the CPU is blocked.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as the CPU port.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_ack  out  1  debug completion pulse.
- dbg_lock  in  1  debug exclusive-ownership request.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, latency counter = 0, last_grant = DBG.
  - All outputs 0: acks, rdata regs, mem_* signals, cpu_hold.
  - An in-flight access is abandoned with no ack.
  - Reset is released synchronously to clk.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests at the clock edge.
  - If dbg_lock = 1: only dbg_req is eligible.
  - Otherwise a single requester is granted directly.
  - If both request: round-robin, the requester not equal to last_grant wins.
  - On grant: latch owner, we, addr, wdata into registers; last_grant = owner; counter = MEM_LAT-1; go to ACCESS.
  - With no eligible request: stay in IDLE, mem_en = 0.
- ACCESS:
  - mem_en = 1; mem_we/addr/wdata driven from the latched registers.
  - Lasts exactly MEM_LAT cycles. Counter decrements each cycle; at 0, mem_rdata is captured (reads) and the FSM goes to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; owner's rdata register holds the captured data.
  - Write acks leave rdata unchanged.
  - Next state is IDLE.
- Latency: request sampled at edge k → ack high in cycle k+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Requesters drop req on the edge that ends the ack cycle. A req still high in IDLE after that is a new transaction.
- Request inputs are ignored outside IDLE; latched values are not affected by input changes mid-access.
- dbg_lock asserted during a CPU access:
  - The CPU access completes normally and is acked.
  - From the next IDLE onward only debug is granted.
  - cpu_hold = dbg_lock & cpu_req (combinational from registered dbg_lock).
- dbg_lock released: round-robin resumes; last_grant is unchanged.
- Non-owner ack and rdata stay 0 and unchanged respectively.
- MEM_LAT outside 1..15 is a configuration error. Simulation reports it with $error at time 0.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs cpu_grant_cnt[15:0], dbg_grant_cnt[15:0] and conflict_cnt[15:0].
  - cpu_grant_cnt and dbg_grant_cnt increment on each grant to that requester.
  - conflict_cnt increments on each IDLE cycle where both requests are eligible.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset/basic read, MEM_LAT = 2:
  - Stimulus: mem holds 32'hDEADBEEF at 0x10; cpu read 0x10 sampled at edge 0.
  - Required: mem_en high cycles 1–2, cpu_ack high cycle 3, cpu_rdata = 32'hDEADBEEF, dbg_ack stays 0.
- Write then read:
  - Stimulus: dbg writes 32'h12345678 to 0x20; cpu then reads 0x20.
  - Required: mem_we = 1 only during the debug ACCESS cycles; cpu_rdata = 32'h12345678.
- Simultaneous requests:
  - Stimulus: both requests held continuously for 4 transactions after reset.
  - Required: grant order CPU, DBG, CPU, DBG; each ack separated by 4 cycles.
- Lock:
  - Stimulus: dbg_lock raised mid CPU access; both requesting.
  - Required: the CPU access acks; the next 3 grants all go to DBG; cpu_hold = 1 throughout; after dbg_lock drops, the next grant is CPU.
- Reset mid-access:
  - Stimulus: rst = 0 in the second ACCESS cycle.
  - Required: mem_en = 0 immediately, no ack; after release, the held request is re-granted with full latency.
- ARB_PERF_EN:
  - Stimulus: 3 conflicts plus 2 lone CPU grants.
  - Required: cpu_grant_cnt = 4, dbg_grant_cnt = 1, conflict_cnt = 3.
  - Counters preloaded near 16'hFFFF hold at 16'hFFFF.
